instruction_fetch_unit: RTL

- Parametrised successor to the single-register fetch stage.
- Owns the PC and issues in-order word fetches to instruction memory over a valid/ready request channel, with a variable-latency, in-order response channel.
- Buffers returned {PC, instruction} pairs in a DEPTH-entry queue feeding decode through a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing the queue and discarding responses still in flight.

---
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - redirect, instruction memory and decode-side signals of the fetch unit
interface instruction_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            REDIRECT_VALID;
    logic [XLEN-1:0] REDIRECT_PC;
    logic            IMEM_REQ_VALID;
    logic            IMEM_REQ_READY;
    logic [XLEN-1:0] IMEM_REQ_ADDR;
    logic            IMEM_RSP_VALID;
    logic [XLEN-1:0] IMEM_RSP_DATA;
    logic            IF_VALID;
    logic            IF_READY;
    logic [XLEN-1:0] IF_PC;
    logic [XLEN-1:0] IF_INSTR;

    modport master (
        input  REDIRECT_VALID, REDIRECT_PC, IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, IF_READY,
        output IMEM_REQ_VALID, IMEM_REQ_ADDR, IF_VALID, IF_PC, IF_INSTR
    );

    modport slave (
        output REDIRECT_VALID, REDIRECT_PC, IMEM_REQ_READY, IMEM_RSP_VALID, IMEM_RSP_DATA, IF_READY,
        input  IMEM_REQ_VALID, IMEM_REQ_ADDR, IF_VALID, IF_PC, IF_INSTR
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner issuing in-order fetches into a DEPTH-entry {pc, instr} queue
module instruction_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              DEPTH        = 4,
    parameter int              PC_STEP      = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    instruction_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_LIM = (CW+2)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic [XLEN-1:0] pc;
    cnt_t            live_cnt;
    cnt_t            kill_cnt;
    cnt_t            q_count;
    ptr_t            q_wr;
    ptr_t            q_rd;
    ptr_t            pend_wr;
    ptr_t            pend_rd;

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic [XLEN-1:0] pend_pc [DEPTH];

    logic [CW+1:0] credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_drop;
    logic          rsp_accept;
    logic          if_pop;
    logic          unused_redirect_lsbs;

    // Killed responses still occupy credits so new fetches can never overtake the queue capacity.
    assign credit_used = {2'b00, live_cnt} + {2'b00, kill_cnt} + {2'b00, q_count};
    assign req_valid   = !RST && !bus.REDIRECT_VALID && (credit_used < DEPTH_LIM);
    assign req_fire    = req_valid && bus.IMEM_REQ_READY;
    assign rsp_drop    = bus.IMEM_RSP_VALID && (kill_cnt != '0);
    assign rsp_accept  = bus.IMEM_RSP_VALID && (kill_cnt == '0) && !bus.REDIRECT_VALID;
    assign if_pop      = (q_count != '0) && bus.IF_READY;

    assign unused_redirect_lsbs = ^bus.REDIRECT_PC[1:0];

    assign bus.IMEM_REQ_VALID = req_valid;
    assign bus.IMEM_REQ_ADDR  = pc;
    assign bus.IF_VALID       = (q_count != '0);
    assign bus.IF_PC          = (q_count != '0) ? q_pc[q_rd]    : '0;
    assign bus.IF_INSTR       = (q_count != '0) ? q_instr[q_rd] : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc       <= RESET_VECTOR;
            live_cnt <= '0;
            kill_cnt <= '0;
            q_count  <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            pend_wr  <= '0;
            pend_rd  <= '0;
        end else if (bus.REDIRECT_VALID) begin
            // Everything in flight becomes garbage; a response landing this cycle is already consumed.
            pc       <= {bus.REDIRECT_PC[XLEN-1:2], 2'b00};
            kill_cnt <= kill_cnt + live_cnt - cnt_t'(bus.IMEM_RSP_VALID);
            live_cnt <= '0;
            q_count  <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            pend_wr  <= '0;
            pend_rd  <= '0;
        end else begin
            if (req_fire) begin
                pc      <= pc + XLEN'(PC_STEP);
                pend_wr <= pend_wr + ptr_t'(1);
            end
            if (rsp_accept) begin
                pend_rd <= pend_rd + ptr_t'(1);
                q_wr    <= q_wr + ptr_t'(1);
            end
            if (if_pop) begin
                q_rd <= q_rd + ptr_t'(1);
            end
            live_cnt <= live_cnt + cnt_t'(req_fire) - cnt_t'(rsp_accept);
            kill_cnt <= kill_cnt - cnt_t'(rsp_drop);
            q_count  <= q_count + cnt_t'(rsp_accept) - cnt_t'(if_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (req_fire) begin
            pend_pc[pend_wr] <= pc;
        end
        if (rsp_accept) begin
            q_pc[q_wr]    <= pend_pc[pend_rd];
            q_instr[q_wr] <= bus.IMEM_RSP_DATA;
        end
    end
endmodule
